// File: rtl/div255_seq_ctrl.sv
// Bit-serial restoring divide-by-255 with valid/ready on both sides.
// Define DIV255_EARLY_EXIT_EN to skip leading zero bytes of the operand.
module div255_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [7:0]       rem,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_xs;
  logic [WIDTH-2:0] r_q;
  logic [WIDTH-1:0] r_y;
  logic [7:0]       r_r;
  logic [7:0]       r_rem;
  logic [CNT_W-1:0] r_cnt;

  logic [8:0]       w_rn;
  logic             w_qb;
  logic [7:0]       w_rs;
  logic             w_acc;
  logic             w_last;
  logic [WIDTH-1:0] w_xs0;
  logic [CNT_W-1:0] w_cnt0;
  logic             w_zero;

  // r never exceeds 254, so only the 9-bit trial value needs the extra bit
  assign w_rn   = {r_r, r_xs[WIDTH-1]};
  assign w_qb   = (w_rn >= 9'd255);
  assign w_rs   = w_qb ? 8'(w_rn - 9'd255) : w_rn[7:0];
  assign w_acc  = in_valid && (r_state == S_IDLE);
  assign w_last = (r_cnt == CNT_W'(1));

`ifdef DIV255_EARLY_EXIT_EN
  logic [CNT_W-1:0] w_sh;
  logic             w_nz;

  always_comb begin
    w_sh = '0;
    w_nz = 1'b0;
    for (int i = WIDTH/8 - 1; i >= 0; i--) begin
      w_nz = w_nz | (x[i*8 +: 8] != 8'd0);
      if (!w_nz) w_sh = w_sh + CNT_W'(8);
    end
  end

  assign w_xs0  = x << w_sh;
  assign w_cnt0 = CNT_W'(WIDTH) - w_sh;
  assign w_zero = (w_sh == CNT_W'(WIDTH));
`else
  assign w_xs0  = x;
  assign w_cnt0 = CNT_W'(WIDTH);
  assign w_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = w_zero ? S_DONE : S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xs  <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_cnt <= '0;
      r_y   <= '0;
      r_rem <= '0;
    end else if (w_acc) begin
      r_xs  <= w_xs0;
      r_q   <= '0;
      r_r   <= '0;
      r_cnt <= w_cnt0;
      if (w_zero) begin
        r_y   <= '0;
        r_rem <= '0;
      end
    end else if (r_state == S_RUN) begin
      r_xs  <= r_xs << 1;
      r_r   <= w_rs;
      r_q   <= {r_q[WIDTH-3:0], w_qb};
      r_cnt <= r_cnt - CNT_W'(1);
      if (w_last) begin
        r_y   <= {r_q, w_qb};
        r_rem <= w_rs;
      end
    end
  end

  assign y   = r_y;
  assign rem = r_rem;

endmodule

// File: tb/tb_div255_seq_ctrl.sv
// Directed bench for div255_seq_ctrl (WIDTH = 32), both build variants.
// Latency expectations follow DIV255_EARLY_EXIT_EN when it is defined.
module tb_div255_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic [7:0]  rem;
  logic        busy;

  int checks;
  int errors;

  div255_seq_ctrl #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .rem       (rem),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one operand, wait (bounded) for the result, then handshake it.
  // cyc counts edges starting with the accept edge as 1.
  task automatic do_op(input logic [31:0] xv, output logic [31:0] yv,
                       output logic [7:0] rv, output int cyc,
                       output logic ok);
    @(negedge clk);
    x         = xv;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    cyc       = 0;
    do begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      cyc++;
    end while (!out_valid && cyc < 200);
    ok = out_valid;
    yv = y;
    rv = rem;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if (y !== 32'd0) begin
      errors++; $display("FAIL reset_y: got %0d want 0", y);
    end
    checks++;
    if (rem !== 8'd0) begin
      errors++; $display("FAIL reset_rem: got %0d want 0", rem);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] yv;
    logic [7:0]  rv;
    int          cyc;
    int          exp_cyc;
    logic        ok;
`ifdef DIV255_EARLY_EXIT_EN
    exp_cyc = 17;
`else
    exp_cyc = 33;
`endif
    do_op(32'd2550, yv, rv, cyc, ok);
    checks++;
    if (cyc !== exp_cyc || ok !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: got %0d (valid %b) want %0d", cyc, ok, exp_cyc);
    end
    checks++;
    if (yv !== 32'd10 || rv !== 8'd0) begin
      errors++; $display("FAIL basic_2550: got y=%0d rem=%0d want 10/0", yv, rv);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] xs [3];
    logic [31:0] ys [3];
    int          bad_ready;
    int          n;
    xs = '{32'd8160, 32'd32640, 32'd4335};
    ys = '{32'd32, 32'd128, 32'd17};
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      x        = xs[k];
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      x = 32'hDEADBEEF;
      bad_ready = 0;
      n = 0;
      while (!out_valid && n < 200) begin
        if (in_ready !== 1'b0) bad_ready++;
        @(posedge clk);
        #1;
        n++;
      end
      checks++;
      if (out_valid !== 1'b1 || y !== ys[k] || rem !== 8'd0) begin
        errors++;
        $display("FAIL b2b_result%0d: got v=%b y=%0d rem=%0d want 1/%0d/0",
                 k, out_valid, y, rem, ys[k]);
      end
      checks++;
      if (bad_ready != 0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_in_ready%0d: got %0d high cycles want 0", k, bad_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_idle%0d: got v=%b rdy=%b want 0/1", k, out_valid, in_ready);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_vectors();
    logic [31:0] xs [3];
    logic [31:0] ys [3];
    logic [7:0]  rs [3];
    logic [31:0] yv;
    logic [7:0]  rv;
    int          cyc;
    logic        ok;
    xs = '{32'd256, 32'hFFFFFFFF, 32'd254};
    ys = '{32'd1, 32'd16843009, 32'd0};
    rs = '{8'd1, 8'd0, 8'd254};
    for (int k = 0; k < 3; k++) begin
      do_op(xs[k], yv, rv, cyc, ok);
      checks++;
      if (ok !== 1'b1 || yv !== ys[k] || rv !== rs[k]) begin
        errors++;
        $display("FAIL vec_%0d: got y=%0d rem=%0d want %0d/%0d",
                 xs[k], yv, rv, ys[k], rs[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    @(negedge clk);
    x         = 32'd5101;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 200);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      x = $urandom;
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          y !== 32'd20 || rem !== 8'd1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got v=%b rdy=%b want 0/1", out_valid, in_ready);
    end
    checks++;
    if (y !== 32'd20 || rem !== 8'd1) begin
      errors++; $display("FAIL bp_idle_hold: got y=%0d rem=%0d want 20/1", y, rem);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] yv;
    logic [7:0]  rv;
    int          cyc;
    logic        ok;
    @(negedge clk);
    x        = 32'd12345;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_busy: got busy=%b rdy=%b want 1/0", busy, in_ready);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 ||
        y !== 32'd0 || rem !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: got v=%b rdy=%b busy=%b y=%0d rem=%0d want 0/1/0/0/0",
               out_valid, in_ready, busy, y, rem);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(32'd4335, yv, rv, cyc, ok);
    checks++;
    if (ok !== 1'b1 || yv !== 32'd17 || rv !== 8'd0) begin
      errors++; $display("FAIL mid_after: got y=%0d rem=%0d want 17/0", yv, rv);
    end
  endtask

  task automatic test_zero();
    logic [31:0] yv;
    logic [7:0]  rv;
    int          cyc;
    int          exp_cyc;
    logic        ok;
`ifdef DIV255_EARLY_EXIT_EN
    exp_cyc = 1;
`else
    exp_cyc = 33;
`endif
    do_op(32'd0, yv, rv, cyc, ok);
    checks++;
    if (cyc !== exp_cyc || ok !== 1'b1) begin
      errors++; $display("FAIL zero_latency: got %0d want %0d", cyc, exp_cyc);
    end
    checks++;
    if (yv !== 32'd0 || rv !== 8'd0) begin
      errors++; $display("FAIL zero_result: got y=%0d rem=%0d want 0/0", yv, rv);
    end
  endtask

  task automatic test_random();
    logic [31:0] xv;
    logic [31:0] yv;
    logic [7:0]  rv;
    logic [31:0] ey;
    logic [7:0]  er;
    int          cyc;
    logic        ok;
    for (int i = 0; i < 1000; i++) begin
      xv = $urandom;
      xv = xv >> (8 * $urandom_range(0, 3));
      ey = xv / 32'd255;
      er = 8'(xv % 32'd255);
      do_op(xv, yv, rv, cyc, ok);
      checks++;
      if (ok !== 1'b1 || yv !== ey || rv !== er) begin
        errors++;
        $display("FAIL rand_%0d: got y=%0d rem=%0d want %0d/%0d", xv, yv, rv, ey, er);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_zero();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
